// File: rtl/tlb_pkg.sv
// Shared types for the TLB / page-table-walker arbitration slice.
package tlb_pkg;

  typedef logic [7:0]  rqst_t;
  typedef logic [63:0] vadd_t;
  typedef logic [63:0] satp_t;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} arb_state_e;

  localparam rqst_t RQST_NONE = 8'h00;

  // Index width for n ports; a single port still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tlb_rr_pick.sv
// Combinational round-robin picker: first set bit of req strictly after ptr, wrapping.
module tlb_rr_pick import tlb_pkg::*; #(
  parameter int unsigned chn = 2,
  localparam int unsigned PW = idx_w(chn)
) (
  input  logic [chn-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic           valid,
  output logic [PW-1:0]  idx
);

  function automatic logic [PW-1:0] wrap(input int unsigned v);
    return PW'(v % chn);
  endfunction

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= chn; k++) begin
      if (!valid && req[wrap(32'(ptr) + k)]) begin
        valid = 1'b1;
        idx   = wrap(32'(ptr) + k);
      end
    end
  end

endmodule

// File: rtl/tlb_ptw_arbiter.sv
// Round-robin share of one PTW port among chn TLB miss ports; abandoned walks are drained.
// Optional counters enabled by defining TLB_PTW_ARB_PERF_EN.
module tlb_ptw_arbiter import tlb_pkg::*; #(
  parameter int unsigned chn = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [255:0]          flush,
  input  rqst_t [chn-1:0]       s_rqst,
  input  vadd_t [chn-1:0]       s_vadd,
  input  satp_t [chn-1:0]       s_satp,
  output rqst_t [chn-1:0]       s_resp,
  output logic [chn-1:0][7:0]   s_perm,
  output logic [chn-1:0][63:0]  s_padd,
  output rqst_t                 m_rqst,
  output vadd_t                 m_vadd,
  output satp_t                 m_satp,
  input  rqst_t                 m_resp,
  input  logic [7:0]            m_perm,
  input  logic [63:0]           m_padd
`ifdef TLB_PTW_ARB_PERF_EN
  ,
  output logic [chn-1:0][31:0]  perf_grant,
  output logic [31:0]           perf_busy,
  output logic [31:0]           perf_drain
`endif
);

  localparam int unsigned PW = idx_w(chn);

  arb_state_e    state, state_nx;
  logic [PW-1:0] ptr, owner;
  rqst_t         hold_id;
  vadd_t         hold_vadd;
  satp_t         hold_satp;

  logic [chn-1:0] elig;
  logic           pick_valid;
  logic [PW-1:0]  pick_idx;
  logic           grant;
  logic           resp_hit;
  logic           abandon;

  for (genvar i = 0; i < chn; i++) begin : g_elig
    assign elig[i] = (s_rqst[i] != RQST_NONE) && !flush[s_rqst[i]];
  end

  tlb_rr_pick #(.chn(chn)) u_pick (
    .req   (elig),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign resp_hit = (m_resp != RQST_NONE);
  assign abandon  = flush[hold_id] || (s_rqst[owner] != hold_id);

  // A response wins over a same-cycle flush/withdraw; the requester filters it.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant    = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (resp_hit)     state_nx = IDLE;
        else if (abandon) state_nx = DRAIN;
      end
      DRAIN: begin
        if (resp_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      hold_id   <= RQST_NONE;
      hold_vadd <= '0;
      hold_satp <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        owner     <= pick_idx;
        ptr       <= pick_idx;
        hold_id   <= s_rqst[pick_idx];
        hold_vadd <= s_vadd[pick_idx];
        hold_satp <= s_satp[pick_idx];
      end
    end
  end

  assign m_rqst = (state == BUSY && !resp_hit) ? hold_id : RQST_NONE;
  assign m_vadd = hold_vadd;
  assign m_satp = hold_satp;

  assign s_perm = {chn{m_perm}};
  assign s_padd = {chn{m_padd}};

  always_comb begin
    s_resp = '0;
    if (state == BUSY) s_resp[owner] = m_resp;
  end

`ifdef TLB_PTW_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant <= '0;
      perf_busy  <= '0;
      perf_drain <= '0;
    end else begin
      if (grant)                                perf_grant[pick_idx] <= perf_grant[pick_idx] + 32'd1;
      if (state != IDLE)                        perf_busy  <= perf_busy + 32'd1;
      if (state == BUSY && state_nx == DRAIN)   perf_drain <= perf_drain + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tlb_ptw_arbiter.sv
// Directed bench for tlb_ptw_arbiter with a walk-level reference model checked every cycle.
module tb_tlb_ptw_arbiter;

  localparam int unsigned CHN = 2;
  localparam int unsigned TPW = $clog2(CHN);
  typedef logic [TPW-1:0] idx_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [255:0]          flush;
  logic [CHN-1:0][7:0]   s_rqst;
  logic [CHN-1:0][63:0]  s_vadd;
  logic [CHN-1:0][63:0]  s_satp;
  logic [CHN-1:0][7:0]   s_resp;
  logic [CHN-1:0][7:0]   s_perm;
  logic [CHN-1:0][63:0]  s_padd;
  logic [7:0]            m_rqst;
  logic [63:0]           m_vadd;
  logic [63:0]           m_satp;
  logic [7:0]            m_resp;
  logic [7:0]            m_perm;
  logic [63:0]           m_padd;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  tlb_ptw_arbiter #(.chn(CHN)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .s_rqst (s_rqst),
    .s_vadd (s_vadd),
    .s_satp (s_satp),
    .s_resp (s_resp),
    .s_perm (s_perm),
    .s_padd (s_padd),
    .m_rqst (m_rqst),
    .m_vadd (m_vadd),
    .m_satp (m_satp),
    .m_resp (m_resp),
    .m_perm (m_perm),
    .m_padd (m_padd)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one walk may be outstanding at the PTW; it is live while its owner still wants it.
  bit          md_on = 1'b0;
  bit          md_walk, md_live;
  idx_t        md_owner, md_last, md_p;
  logic [7:0]  md_id;
  logic [63:0] md_va, md_sa;

  always @(posedge clk) begin
    if (rst) begin
      md_on = 1'b1; md_walk = 1'b0; md_live = 1'b0;
      md_owner = '0; md_last = '0; md_id = '0; md_va = '0; md_sa = '0;
    end else if (!md_walk) begin
      for (int unsigned k = 1; k <= CHN; k++) begin
        md_p = idx_t'((32'(md_last) + k) % CHN);
        if (!md_walk && s_rqst[md_p] != 8'h00 && !flush[s_rqst[md_p]]) begin
          md_walk = 1'b1; md_live = 1'b1;
          md_owner = md_p; md_last = md_p;
          md_id = s_rqst[md_p]; md_va = s_vadd[md_p]; md_sa = s_satp[md_p];
        end
      end
    end else if (m_resp != 8'h00) begin
      md_walk = 1'b0; md_live = 1'b0;
    end else if (md_live && (flush[md_id] || s_rqst[md_owner] != md_id)) begin
      md_live = 1'b0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (md_on) begin
      check("m_rqst", 64'(m_rqst), 64'((md_walk && md_live && m_resp == 8'h00) ? md_id : 8'h00));
      check("m_vadd", m_vadd, md_va);
      check("m_satp", m_satp, md_sa);
      for (int unsigned i = 0; i < CHN; i++) begin
        check($sformatf("s_resp[%0d]", i), 64'(s_resp[idx_t'(i)]),
              64'((md_walk && md_live && md_owner == idx_t'(i)) ? m_resp : 8'h00));
        check($sformatf("s_perm[%0d]", i), 64'(s_perm[idx_t'(i)]), 64'(m_perm));
        check($sformatf("s_padd[%0d]", i), s_padd[idx_t'(i)], m_padd);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = '0; s_rqst = '0; s_vadd = '0; s_satp = '0;
    m_resp = 8'h00; m_perm = 8'h00; m_padd = '0;
    cyc(); cyc();
    rst = 1'b0; #1;
    check("reset m_rqst", 64'(m_rqst), 64'h0);
    check("reset m_vadd", m_vadd, 64'h0);
    check("reset s_resp", 64'(s_resp), 64'h0);

    // single walk
    cyc(); s_rqst[0] = 8'h05; s_vadd[0] = 64'h0000_0040_1234_5000; s_satp[0] = 64'h8000_0000_0008_0000; #1;
    check("walk T m_rqst", 64'(m_rqst), 64'h0);
    cyc(); #1;
    check("walk T+1 m_rqst", 64'(m_rqst), 64'h05);
    check("walk T+1 m_vadd", m_vadd, 64'h0000_0040_1234_5000);
    check("walk T+1 m_satp", m_satp, 64'h8000_0000_0008_0000);
    cyc(); cyc();
    cyc(); m_resp = 8'h05; m_perm = 8'h1f; m_padd = 64'h8020_0000; #1;
    check("walk resp s_resp0", 64'(s_resp[0]), 64'h05);
    check("walk resp s_perm0", 64'(s_perm[0]), 64'h1f);
    check("walk resp s_padd0", s_padd[0], 64'h8020_0000);
    check("walk resp m_rqst", 64'(m_rqst), 64'h0);
    check("walk resp s_resp1", 64'(s_resp[1]), 64'h0);
    cyc(); m_resp = 8'h00; m_perm = 8'h00; m_padd = '0; s_rqst[0] = 8'h00; #1;
    check("walk T+5 m_rqst", 64'(m_rqst), 64'h0);
    cyc(); #1;
    check("walk T+6 m_rqst", 64'(m_rqst), 64'h0);

    // fairness: ptr=0, both ports hold requests
    cyc(); s_rqst[0] = 8'h03; s_rqst[1] = 8'h07; s_vadd[1] = 64'h1111_2000;
    cyc(); #1; check("fair g1 m_rqst", 64'(m_rqst), 64'h07);
    cyc(); m_resp = 8'h07; #1;
    check("fair r1 s_resp1", 64'(s_resp[1]), 64'h07);
    check("fair r1 s_resp0", 64'(s_resp[0]), 64'h0);
    cyc(); m_resp = 8'h00; #1; check("fair idle m_rqst", 64'(m_rqst), 64'h0);
    cyc(); #1; check("fair g2 m_rqst", 64'(m_rqst), 64'h03);
    check("fair g2 m_vadd", m_vadd, 64'h0000_0040_1234_5000);
    cyc(); m_resp = 8'h03; #1;
    check("fair r2 s_resp0", 64'(s_resp[0]), 64'h03);
    check("fair r2 s_resp1", 64'(s_resp[1]), 64'h0);
    cyc(); m_resp = 8'h00;
    cyc(); #1; check("fair g3 m_rqst", 64'(m_rqst), 64'h07);
    cyc(); m_resp = 8'h07; #1; check("fair r3 s_resp1", 64'(s_resp[1]), 64'h07);
    cyc(); m_resp = 8'h00; s_rqst = '0;
    cyc();

    // flush mid-walk, ptr=1
    cyc(); s_rqst[0] = 8'h09;
    cyc(); #1; check("flush busy m_rqst", 64'(m_rqst), 64'h09);
    cyc(); flush[8'h09] = 1'b1; #1; check("flush T m_rqst", 64'(m_rqst), 64'h09);
    cyc(); flush = '0; s_rqst[0] = 8'h00; s_rqst[1] = 8'h04; #1;
    check("flush T+1 m_rqst", 64'(m_rqst), 64'h0);
    cyc(); #1; check("flush T+2 m_rqst", 64'(m_rqst), 64'h0);
    cyc(); m_resp = 8'h09; #1;
    check("drain s_resp0", 64'(s_resp[0]), 64'h0);
    check("drain s_resp1", 64'(s_resp[1]), 64'h0);
    cyc(); m_resp = 8'h00; #1; check("flush T+4 m_rqst", 64'(m_rqst), 64'h0);
    cyc(); #1; check("flush T+5 m_rqst", 64'(m_rqst), 64'h04);
    cyc(); m_resp = 8'h04; #1; check("flush r s_resp1", 64'(s_resp[1]), 64'h04);
    cyc(); m_resp = 8'h00; s_rqst = '0;
    cyc();

    // response and flush together, ptr=1
    cyc(); s_rqst[0] = 8'h09;
    cyc(); #1; check("simul m_rqst", 64'(m_rqst), 64'h09);
    cyc(); m_resp = 8'h09; m_perm = 8'h0f; m_padd = 64'h1234_0000; flush[8'h09] = 1'b1; #1;
    check("simul s_resp0", 64'(s_resp[0]), 64'h09);
    check("simul s_padd0", s_padd[0], 64'h1234_0000);
    cyc(); m_resp = 8'h00; m_perm = 8'h00; m_padd = '0; flush = '0; s_rqst = '0; #1;
    check("simul after m_rqst", 64'(m_rqst), 64'h0);
    cyc(); #1; check("simul idle m_rqst", 64'(m_rqst), 64'h0);

    // page fault, ptr=0
    cyc(); s_rqst[1] = 8'h06;
    cyc(); #1; check("pf m_rqst", 64'(m_rqst), 64'h06);
    cyc(); m_resp = 8'h06; m_perm = 8'h00; m_padd = 64'hdead_0000; #1;
    check("pf s_resp1", 64'(s_resp[1]), 64'h06);
    check("pf s_perm1", 64'(s_perm[1]), 64'h0);
    cyc(); m_resp = 8'h00; m_padd = '0; s_rqst = '0;
    cyc();

    // reset mid-walk, ptr=1
    cyc(); s_rqst[0] = 8'h05;
    cyc(); #1; check("rst busy m_rqst", 64'(m_rqst), 64'h05);
    cyc(); rst = 1'b1; s_rqst[0] = 8'h00;
    cyc(); rst = 1'b0; #1;
    check("rst after m_rqst", 64'(m_rqst), 64'h0);
    check("rst after m_vadd", m_vadd, 64'h0);
    cyc(); m_resp = 8'h05; #1;
    check("stray s_resp0", 64'(s_resp[0]), 64'h0);
    check("stray s_resp1", 64'(s_resp[1]), 64'h0);
    cyc(); m_resp = 8'h00;

    // owner withdraws and re-requests, ptr=0
    cyc(); s_rqst[1] = 8'h22;
    cyc(); #1; check("wd g m_rqst", 64'(m_rqst), 64'h22);
    cyc(); s_rqst[1] = 8'h23; #1; check("wd chg m_rqst", 64'(m_rqst), 64'h22);
    cyc(); #1; check("wd drain m_rqst", 64'(m_rqst), 64'h0);
    cyc(); m_resp = 8'h22; #1; check("wd swallow s_resp1", 64'(s_resp[1]), 64'h0);
    cyc(); m_resp = 8'h00; #1; check("wd idle m_rqst", 64'(m_rqst), 64'h0);
    cyc(); #1; check("wd regrant m_rqst", 64'(m_rqst), 64'h23);
    cyc(); m_resp = 8'h23; #1; check("wd resp s_resp1", 64'(s_resp[1]), 64'h23);
    cyc(); m_resp = 8'h00; s_rqst = '0;
    cyc();

    // a flushed ID is not eligible, ptr=1
    cyc(); s_rqst[0] = 8'h11; flush[8'h11] = 1'b1;
    cyc(); #1; check("inelig m_rqst", 64'(m_rqst), 64'h0);
    cyc(); flush = '0;
    cyc(); #1; check("elig m_rqst", 64'(m_rqst), 64'h11);
    cyc(); m_resp = 8'h11; #1; check("elig s_resp0", 64'(s_resp[0]), 64'h11);
    cyc(); m_resp = 8'h00; s_rqst = '0;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
